// File: rtl/absorb_accumulator.sv
// Per-voxel weight accumulator: read-modify-write on a simple-dual-port RAM with distance-1
// forwarding, saturating adds, a post-reset clear sweep and a clear-on-read host drain stream.
module absorb_accumulator #(
   parameter int ADDR_WIDTH  = 16,
   parameter int WORD_WIDTH  = 64,
   parameter int DELTA_WIDTH = 32,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   i_valid,
   input  logic [ADDR_WIDTH-1:0]  i_addr,
   input  logic [DELTA_WIDTH-1:0] i_delta,
   output logic                   o_in_ready,
   input  logic                   i_clear_start,
   input  logic                   i_drain_start,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_rd_valid,
   output logic [ADDR_WIDTH-1:0]  o_rd_addr,
   output logic [WORD_WIDTH-1:0]  o_rd_data,
   input  logic                   i_rd_ready,
   output logic                   o_sat,
   output logic [CNT_WIDTH-1:0]   o_count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int PAD   = WORD_WIDTH + 1 - DELTA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {S_CLEAR, S_ACCUM, S_FLUSH_C, S_FLUSH_D, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic                    issued_all_q, issued_all_d;
   logic                    pend_q, pend_d;
   logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
   logic                    out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
   logic [WORD_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    s1_valid_q, s1_valid_d;
   logic [ADDR_WIDTH-1:0]   s1_addr_q, s1_addr_d;
   logic [DELTA_WIDTH-1:0]  s1_delta_q, s1_delta_d;
   logic                    fwd_valid_q, fwd_valid_d;
   logic [ADDR_WIDTH-1:0]   fwd_addr_q, fwd_addr_d;
   logic [WORD_WIDTH-1:0]   fwd_data_q, fwd_data_d;
   logic                    sat_q, sat_d;
   logic [CNT_WIDTH-1:0]    count_q, count_d;
   logic                    done_q, done_d;

   logic [WORD_WIDTH-1:0]   ram_q [DEPTH];
   logic [WORD_WIDTH-1:0]   rd_data_q;
   logic                    wr_req, rd_req, ram_we, ram_re;
   logic [ADDR_WIDTH-1:0]   ram_waddr, ram_raddr;
   logic [WORD_WIDTH-1:0]   ram_wdata;

   logic                    start_any, accept, rd_hs, move;
   logic [WORD_WIDTH-1:0]   old_word, sum_word;
   logic [WORD_WIDTH:0]     sum_ext, delta_ext;

   // Read-before-write RAM: a same-cycle read of the written address returns the old word.
   always_ff @(posedge clock) begin
      if (ram_we) ram_q[ram_waddr] <= ram_wdata;
      if (ram_re) rd_data_q <= ram_q[ram_raddr];
   end

   assign ram_we = wr_req & enable & ~reset;
   assign ram_re = rd_req & enable & ~reset;

   assign start_any  = i_clear_start | i_drain_start;
   assign o_in_ready = (state_q == S_ACCUM) & ~start_any;
   assign accept     = o_in_ready & i_valid & enable;
   assign rd_hs      = (state_q == S_DRAIN) & out_valid_q & i_rd_ready & enable;
   assign move       = pend_q & (~out_valid_q | rd_hs);

   // The RAM has not yet seen the previous cycle's write when this deposit was read.
   assign old_word  = (fwd_valid_q && fwd_addr_q == s1_addr_q) ? fwd_data_q : rd_data_q;
   assign delta_ext = {{PAD{1'b0}}, s1_delta_q};
   assign sum_ext   = {1'b0, old_word} + delta_ext;
   assign sum_word  = sum_ext[WORD_WIDTH] ? '1 : sum_ext[WORD_WIDTH-1:0];

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      issued_all_d = issued_all_q;
      pend_d       = pend_q;
      pend_addr_d  = pend_addr_q;
      out_valid_d  = out_valid_q;
      out_addr_d   = out_addr_q;
      out_data_d   = out_data_q;
      sat_d        = sat_q;
      count_d      = count_q;
      done_d       = 1'b0;
      s1_valid_d   = accept;
      s1_addr_d    = i_addr;
      s1_delta_d   = i_delta;
      fwd_valid_d  = s1_valid_q;
      fwd_addr_d   = s1_addr_q;
      fwd_data_d   = sum_word;
      wr_req       = s1_valid_q;
      ram_waddr    = s1_addr_q;
      ram_wdata    = sum_word;
      rd_req       = 1'b0;
      ram_raddr    = i_addr;

      if (s1_valid_q && sum_ext[WORD_WIDTH]) sat_d = 1'b1;

      case (state_q)
         S_CLEAR: begin
            wr_req    = 1'b1;
            ram_waddr = ptr_q;
            ram_wdata = '0;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == LAST_ADDR) begin
               state_d = S_ACCUM;
               done_d  = 1'b1;
            end
         end
         S_ACCUM: begin
            rd_req = accept;
            if (accept && count_q != '1) count_d = count_q + 1'b1;
            if (i_clear_start)      state_d = S_FLUSH_C;
            else if (i_drain_start) state_d = S_FLUSH_D;
         end
         S_FLUSH_C: begin
            ptr_d   = '0;
            sat_d   = 1'b0;
            count_d = '0;
            state_d = S_CLEAR;
         end
         S_FLUSH_D: begin
            ptr_d        = '0;
            issued_all_d = 1'b0;
            pend_d       = 1'b0;
            out_valid_d  = 1'b0;
            state_d      = S_DRAIN;
         end
         S_DRAIN: begin
            if (rd_hs) begin
               wr_req      = 1'b1;
               ram_waddr   = out_addr_q;
               ram_wdata   = '0;
               out_valid_d = 1'b0;
            end
            // The RAM output register holds the prefetched word until it moves to the output.
            if (move) begin
               out_valid_d = 1'b1;
               out_addr_d  = pend_addr_q;
               out_data_d  = rd_data_q;
               pend_d      = 1'b0;
            end
            if (!issued_all_q && (!pend_q || move)) begin
               rd_req      = 1'b1;
               ram_raddr   = ptr_q;
               pend_d      = 1'b1;
               pend_addr_d = ptr_q;
               ptr_d       = ptr_q + 1'b1;
               if (ptr_q == LAST_ADDR) issued_all_d = 1'b1;
            end
            if (rd_hs && out_addr_q == LAST_ADDR) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
               state_d     = S_ACCUM;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_CLEAR;
         ptr_q        <= '0;
         issued_all_q <= 1'b0;
         pend_q       <= 1'b0;
         pend_addr_q  <= '0;
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         out_data_q   <= '0;
         s1_valid_q   <= 1'b0;
         s1_addr_q    <= '0;
         s1_delta_q   <= '0;
         fwd_valid_q  <= 1'b0;
         fwd_addr_q   <= '0;
         fwd_data_q   <= '0;
         sat_q        <= 1'b0;
         count_q      <= '0;
         done_q       <= 1'b0;
      end else if (enable) begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         issued_all_q <= issued_all_d;
         pend_q       <= pend_d;
         pend_addr_q  <= pend_addr_d;
         out_valid_q  <= out_valid_d;
         out_addr_q   <= out_addr_d;
         out_data_q   <= out_data_d;
         s1_valid_q   <= s1_valid_d;
         s1_addr_q    <= s1_addr_d;
         s1_delta_q   <= s1_delta_d;
         fwd_valid_q  <= fwd_valid_d;
         fwd_addr_q   <= fwd_addr_d;
         fwd_data_q   <= fwd_data_d;
         sat_q        <= sat_d;
         count_q      <= count_d;
         done_q       <= done_d;
      end
   end

   assign o_busy     = (state_q != S_ACCUM);
   assign o_done     = done_q;
   assign o_rd_valid = out_valid_q;
   assign o_rd_addr  = out_addr_q;
   assign o_rd_data  = out_data_q;
   assign o_sat      = sat_q;
   assign o_count    = count_q;

endmodule

// File: tb/tb_absorb_accumulator.sv
// Directed plus randomized bench for absorb_accumulator (16 words of 8 bits) against a
// per-voxel saturating array model.
module tb_absorb_accumulator;

   logic       clock = 1'b0;
   logic       reset, enable, i_valid, i_clear_start, i_drain_start, i_rd_ready;
   logic [3:0] i_addr;
   logic [7:0] i_delta;
   logic       o_in_ready, o_busy, o_done, o_rd_valid, o_sat;
   logic [3:0] o_rd_addr;
   logic [7:0] o_rd_data, o_count;

   int checks = 0;
   int errors = 0;
   int model_mem [16];
   int model_count = 0;
   int model_sat = 0;

   absorb_accumulator #(.ADDR_WIDTH(4), .WORD_WIDTH(8), .DELTA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .i_valid(i_valid), .i_addr(i_addr), .i_delta(i_delta), .o_in_ready(o_in_ready),
      .i_clear_start(i_clear_start), .i_drain_start(i_drain_start),
      .o_busy(o_busy), .o_done(o_done),
      .o_rd_valid(o_rd_valid), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
      .i_rd_ready(i_rd_ready), .o_sat(o_sat), .o_count(o_count)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_apply(input int a, input int d);
      if (model_mem[a] + d > 255) begin
         model_mem[a] = 255;
         model_sat = 1;
      end else begin
         model_mem[a] = model_mem[a] + d;
      end
      if (model_count < 255) model_count++;
   endtask

   task automatic model_wipe;
      for (int i = 0; i < 16; i++) model_mem[i] = 0;
      model_count = 0;
      model_sat = 0;
   endtask

   task automatic deposit(input int a, input int d);
      chk("in_ready", 32'(o_in_ready), 1);
      i_valid = 1'b1;
      i_addr  = 4'(a);
      i_delta = 8'(d);
      model_apply(a, d);
      tick;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) tick;
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
   task automatic do_drain(input int mode);
      int exp_a, cyc;
      logic stall, rdy;
      logic [3:0] pa, pat;
      logic [7:0] pd;
      pat = 4'b1001;
      i_drain_start = 1'b1;
      tick;
      i_drain_start = 1'b0;
      chk("drain_busy", 32'(o_busy), 1);
      exp_a = 0; cyc = 0; stall = 1'b0; pa = '0; pd = '0;
      while (exp_a < 16 && cyc < 400) begin
         if (stall) begin
            chk("stall_valid", 32'(o_rd_valid), 1);
            chk("stall_addr", 32'(o_rd_addr), 32'(pa));
            chk("stall_data", 32'(o_rd_data), 32'(pd));
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = pat[cyc % 4];
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         i_rd_ready = rdy;
         if (o_rd_valid && rdy) begin
            chk("drain_addr", 32'(o_rd_addr), exp_a);
            chk("drain_data", 32'(o_rd_data), model_mem[exp_a]);
            model_mem[exp_a] = 0;
            exp_a++;
            stall = 1'b0;
         end else begin
            stall = o_rd_valid;
            pa = o_rd_addr;
            pd = o_rd_data;
         end
         tick;
         cyc++;
      end
      i_rd_ready = 1'b0;
      chk("drain_words", exp_a, 16);
      chk("drain_done", 32'(o_done), 1);
      chk("drain_valid_low", 32'(o_rd_valid), 0);
      chk("drain_idle", 32'(o_busy), 0);
      chk("drain_count_kept", 32'(o_count), model_count);
      chk("drain_sat_kept", 32'(o_sat), model_sat);
   endtask

   initial begin
      int n;
      logic busy_ok, blocked_ok, v, en;
      int a, d;
      reset = 1'b1; enable = 1'b1; i_valid = 1'b0; i_addr = '0; i_delta = '0;
      i_clear_start = 1'b0; i_drain_start = 1'b0; i_rd_ready = 1'b0;
      model_wipe();
      repeat (3) tick;
      chk("rst_busy", 32'(o_busy), 1);
      chk("rst_in_ready", 32'(o_in_ready), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_rd_valid", 32'(o_rd_valid), 0);
      chk("rst_rd_addr", 32'(o_rd_addr), 0);
      chk("rst_rd_data", 32'(o_rd_data), 0);
      chk("rst_sat", 32'(o_sat), 0);
      chk("rst_count", 32'(o_count), 0);

      // post-reset clear sweep
      reset = 1'b0;
      n = 0; busy_ok = 1'b1;
      while (!o_done && n < 100) begin
         if (!o_busy) busy_ok = 1'b0;
         tick;
         n++;
      end
      chk("clear_cycles", n, 16);
      chk("clear_busy_held", 32'(busy_ok), 1);
      chk("clear_in_ready", 32'(o_in_ready), 1);
      chk("clear_busy_low", 32'(o_busy), 0);
      do_drain(0);

      // back-to-back same address exercises forwarding
      deposit(3, 5); deposit(3, 7); deposit(3, 1);
      idle(2);
      chk("fwd_count", 32'(o_count), 3);
      do_drain(0);

      // interleaved addresses with a stalling host
      deposit(2, 10); deposit(5, 1); deposit(2, 4);
      idle(2);
      do_drain(1);
      do_drain(1);

      // saturation, then clear
      deposit(0, 200); deposit(0, 100);
      idle(2);
      chk("sat_set", 32'(o_sat), 1);
      chk("sat_count", 32'(o_count), model_count);
      i_clear_start = 1'b1;
      #1;
      chk("clear_drops_ready", 32'(o_in_ready), 0);
      tick;
      i_clear_start = 1'b0;
      n = 1;
      while (!o_done && n < 100) begin
         tick;
         n++;
      end
      model_wipe();
      chk("clear_sweep_cycles", n, 18);
      chk("clear_sat", 32'(o_sat), 0);
      chk("clear_count", 32'(o_count), 0);
      do_drain(2);

      // random deposits with gaps and enable stalls
      for (int k = 0; k < 200; k++) begin
         v  = ($urandom_range(0, 3) != 0);
         en = ($urandom_range(0, 7) != 0);
         a  = int'($urandom_range(0, 15));
         d  = int'($urandom_range(0, 40));
         i_valid = v; enable = en; i_addr = 4'(a); i_delta = 8'(d);
         if (v && en) model_apply(a, d);
         tick;
      end
      enable = 1'b1;
      idle(3);
      chk("rand_sat", 32'(o_sat), model_sat);
      chk("rand_count", 32'(o_count), model_count);
      for (int k = 0; k < 150; k++) deposit(int'($urandom_range(0, 15)), 0);
      idle(3);
      chk("count_saturates", 32'(o_count), model_count);
      do_drain(2);

      // reset in the middle of a drain
      deposit(7, 33);
      idle(2);
      i_drain_start = 1'b1;
      tick;
      i_drain_start = 1'b0;
      i_rd_ready = 1'b1;
      repeat (6) tick;
      reset = 1'b1;
      tick;
      chk("mid_rst_valid", 32'(o_rd_valid), 0);
      chk("mid_rst_busy", 32'(o_busy), 1);
      reset = 1'b0;
      i_rd_ready = 1'b0;
      i_valid = 1'b1; i_addr = 4'd1; i_delta = 8'd9;
      n = 0; blocked_ok = 1'b1;
      while (!o_done && n < 100) begin
         if (o_in_ready) blocked_ok = 1'b0;
         i_drain_start = (n == 3);
         tick;
         n++;
      end
      i_valid = 1'b0;
      i_drain_start = 1'b0;
      model_wipe();
      chk("restart_cycles", n, 16);
      chk("restart_blocked", 32'(blocked_ok), 1);
      chk("restart_count", 32'(o_count), 0);
      chk("restart_sat", 32'(o_sat), 0);
      do_drain(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
